// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared constants, state type and tap table for the LFSR encoder/decrypter pair
//
// Contents:
//    ENC_BASE, MSG_LEN, PREL_MIN, PREL_MAX - default geometry of the encrypted message
//    PREAMBLE_CHAR                         - ASCII '_' used as preamble filler
//    TAP_TABLE                             - the six legal 6-bit tap patterns
//    enc_state_e                           - encoder state type
//    tap_lookup()                          - tap table index with out-of-range fallback to entry 0
package lfsr_pkg;

   localparam int unsigned ENC_BASE = 64;
   localparam int unsigned MSG_LEN  = 64;
   localparam int unsigned PREL_MIN = 7;
   localparam int unsigned PREL_MAX = 15;

   localparam logic [7:0] PREAMBLE_CHAR = 8'h5F;

   localparam logic [5:0] TAP_TABLE [0:5] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_MSG  = 2'd2,
      ST_FIN  = 2'd3
   } enc_state_e;

   function automatic logic [5:0] tap_lookup(input logic [2:0] sel);
      case (sel)
         3'd1:    return TAP_TABLE[1];
         3'd2:    return TAP_TABLE[2];
         3'd3:    return TAP_TABLE[3];
         3'd4:    return TAP_TABLE[4];
         3'd5:    return TAP_TABLE[5];
         default: return TAP_TABLE[0];
      endcase
   endfunction

endpackage

// File: rtl/lfsr6_step.sv
// rtl/lfsr6_step.sv - one step of a 6-bit Fibonacci LFSR
//
// Ports:
//    state_i [5:0] - current LFSR state
//    taps_i  [5:0] - feedback tap mask
//    next_o  [5:0] - state after one shift; new bit enters at the LSB
module lfsr6_step (
   input  logic [5:0] state_i,
   input  logic [5:0] taps_i,
   output logic [5:0] next_o
);

   assign next_o = {state_i[4:0], ^(state_i & taps_i)};

endmodule

// File: rtl/lfsr_encoder.sv
// rtl/lfsr_encoder.sv - writes preamble plus LFSR-scrambled plaintext into data memory
//
// Ports:
//    clk       - system clock, rising edge
//    init_n    - asynchronous active-low reset
//    start     - single-cycle request, honoured only in IDLE or FIN
//    prel      - requested preamble length, saturated to [PREL_MIN, PREL_MAX]
//    tap_sel   - tap table index, values above 5 select entry 0
//    seed      - initial LFSR state, zero is replaced by 6'h01
//    mem_raddr - plaintext read address (data returns one cycle later)
//    mem_rdata - plaintext read data
//    mem_waddr - encrypted byte write address
//    mem_wdata - encrypted byte
//    mem_we    - write enable, one byte per cycle for 64 cycles
//    busy      - high while writing (PRE, MSG)
//    done      - high in FIN
//    cfg_err   - tap_sel or seed was substituted on the last start
module lfsr_encoder #(
   parameter int unsigned ENC_BASE = lfsr_pkg::ENC_BASE,
   parameter int unsigned MSG_LEN  = lfsr_pkg::MSG_LEN,
   parameter int unsigned PREL_MIN = lfsr_pkg::PREL_MIN,
   parameter int unsigned PREL_MAX = lfsr_pkg::PREL_MAX
) (
   input  logic       clk,
   input  logic       init_n,
   input  logic       start,
   input  logic [7:0] prel,
   input  logic [2:0] tap_sel,
   input  logic [5:0] seed,
   output logic [7:0] mem_raddr,
   input  logic [7:0] mem_rdata,
   output logic [7:0] mem_waddr,
   output logic [7:0] mem_wdata,
   output logic       mem_we,
   output logic       busy,
   output logic       done,
   output logic       cfg_err
);

   import lfsr_pkg::*;

   localparam logic [7:0] BASE8    = 8'(ENC_BASE);
   localparam logic [7:0] LAST_IDX = 8'(MSG_LEN - 1);
   localparam logic [7:0] PL_MIN8  = 8'(PREL_MIN);
   localparam logic [7:0] PL_MAX8  = 8'(PREL_MAX);

   enc_state_e state_q, state_d;
   logic [7:0] cnt_q, cnt_d;       // byte index 0..MSG_LEN-1 across preamble and message
   logic [7:0] pl_q, pl_d;
   logic [5:0] taps_q, taps_d;
   logic [5:0] lfsr_q, lfsr_d;
   logic       cfg_err_q, cfg_err_d;
   logic [5:0] lfsr_next;

   logic       seed_fix;
   logic       tap_fix;
   logic [7:0] prel_sat;

   lfsr6_step u_step (
      .state_i (lfsr_q),
      .taps_i  (taps_q),
      .next_o  (lfsr_next)
   );

   assign seed_fix = (seed == 6'h00);
   assign tap_fix  = (tap_sel > 3'd5);
   assign prel_sat = (prel < PL_MIN8) ? PL_MIN8 :
                     (prel > PL_MAX8) ? PL_MAX8 : prel;

   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 8'h00;
         pl_q      <= 8'h00;
         taps_q    <= 6'h00;
         lfsr_q    <= 6'h00;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pl_q      <= pl_d;
         taps_q    <= taps_d;
         lfsr_q    <= lfsr_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   // Outputs are decoded from the state register so that the asynchronous
   // reset forces every memory strobe low in the same cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pl_d      = pl_q;
      taps_d    = taps_q;
      lfsr_d    = lfsr_q;
      cfg_err_d = cfg_err_q;
      mem_we    = 1'b0;
      mem_waddr = 8'h00;
      mem_wdata = 8'h00;
      mem_raddr = 8'h00;

      case (state_q)
         ST_IDLE, ST_FIN: begin
            if (start) begin
               state_d   = ST_PRE;
               cnt_d     = 8'h00;
               pl_d      = prel_sat;
               taps_d    = tap_lookup(tap_sel);
               lfsr_d    = seed_fix ? 6'h01 : seed;
               cfg_err_d = seed_fix | tap_fix;
            end
         end

         ST_PRE: begin
            mem_we    = 1'b1;
            mem_waddr = BASE8 + cnt_q;
            mem_wdata = PREAMBLE_CHAR ^ {2'b00, lfsr_q};
            lfsr_d    = lfsr_next;
            cnt_d     = cnt_q + 8'd1;
            if (cnt_q == pl_q - 8'd1) begin
               // Launch the read of plaintext byte 0 so it lands on the first MSG cycle.
               mem_raddr = 8'h00;
               state_d   = ST_MSG;
            end
         end

         ST_MSG: begin
            mem_we    = 1'b1;
            mem_waddr = BASE8 + cnt_q;
            mem_wdata = mem_rdata ^ {2'b00, lfsr_q};
            // Prefetch plaintext byte j+1 where j = cnt - pl.
            mem_raddr = cnt_q - pl_q + 8'd1;
            lfsr_d    = lfsr_next;
            cnt_d     = cnt_q + 8'd1;
            if (cnt_q == LAST_IDX) begin
               state_d = ST_FIN;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy    = (state_q == ST_PRE) || (state_q == ST_MSG);
   assign done    = (state_q == ST_FIN);
   assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_lfsr_encoder.sv
// tb/tb_lfsr_encoder.sv - scoreboard bench for lfsr_encoder
//
// Ports: none (top-level bench). Plaintext lives in plain[0:63], encrypted
// writes land in enc_mem; a registered read path gives the one-cycle latency.
module tb_lfsr_encoder;

   logic       clk = 1'b0;
   logic       init_n;
   logic       start;
   logic [7:0] prel;
   logic [2:0] tap_sel;
   logic [5:0] seed;
   logic [7:0] mem_raddr;
   logic [7:0] mem_rdata;
   logic [7:0] mem_waddr;
   logic [7:0] mem_wdata;
   logic       mem_we;
   logic       busy;
   logic       done;
   logic       cfg_err;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] plain   [0:63];
   logic [7:0] enc_mem [0:255];
   logic [7:0] rdata_q;
   logic [7:0] exp_addr_q [$];
   logic [7:0] exp_data_q [$];
   logic [5:0] stream [0:63];
   int         model_pl;

   always #5 clk = ~clk;

   lfsr_encoder dut (
      .clk       (clk),
      .init_n    (init_n),
      .start     (start),
      .prel      (prel),
      .tap_sel   (tap_sel),
      .seed      (seed),
      .mem_raddr (mem_raddr),
      .mem_rdata (mem_rdata),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .busy      (busy),
      .done      (done),
      .cfg_err   (cfg_err)
   );

   always @(posedge clk) begin
      if (mem_we) enc_mem[mem_waddr] <= mem_wdata;
      rdata_q <= (mem_raddr < 8'd64) ? plain[mem_raddr[5:0]] : 8'h00;
   end
   assign mem_rdata = rdata_q;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference model: corrections, preamble, stream and plaintext XOR.
   task automatic build_expected(input logic [7:0] p, input logic [2:0] ts, input logic [5:0] sd);
      logic [5:0] t;
      logic [5:0] l;
      logic [7:0] b;
      case (ts)
         3'd0: t = 6'h21;
         3'd1: t = 6'h2D;
         3'd2: t = 6'h30;
         3'd3: t = 6'h33;
         3'd4: t = 6'h36;
         3'd5: t = 6'h39;
         default: t = 6'h21;
      endcase
      model_pl = (p < 8'd7) ? 7 : (p > 8'd15) ? 15 : int'(p);
      l = (sd == 6'h00) ? 6'h01 : sd;
      for (int i = 0; i < 64; i++) begin
         b = (i < model_pl) ? 8'h5F : plain[i - model_pl];
         stream[i] = l;
         exp_addr_q.push_back(8'(64 + i));
         exp_data_q.push_back(b ^ {2'b00, l});
         l = {l[4:0], ^(l & t)};
      end
   endtask

   always @(negedge clk) begin : monitor
      logic [7:0] a;
      logic [7:0] d;
      if (mem_we) begin
         if (exp_addr_q.size() == 0) begin
            check("unexpected_we", 32'(mem_we), 32'd0);
         end else begin
            a = exp_addr_q.pop_front();
            d = exp_data_q.pop_front();
            check("waddr", 32'(mem_waddr), 32'(a));
            check("wdata", 32'(mem_wdata), 32'(d));
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_we"},     32'(mem_we),    32'd0);
      check({tag, "_busy"},   32'(busy),      32'd0);
      check({tag, "_done"},   32'(done),      32'd0);
      check({tag, "_cfgerr"}, 32'(cfg_err),   32'd0);
      check({tag, "_raddr"},  32'(mem_raddr), 32'd0);
      check({tag, "_waddr"},  32'(mem_waddr), 32'd0);
      check({tag, "_wdata"},  32'(mem_wdata), 32'd0);
   endtask

   // Called at posedge+1. abort_at != 0 asserts reset in that cycle of the run.
   task automatic run_job(input logic [7:0] p, input logic [2:0] ts, input logic [5:0] sd,
                          input bit poke, input int abort_at);
      int cyc;
      build_expected(p, ts, sd);
      prel = p; tap_sel = ts; seed = sd; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      check("done_drop", 32'(done), 32'd0);
      check("busy_on",   32'(busy), 32'd1);
      while (!done && cyc < 200) begin
         if (abort_at != 0 && cyc == abort_at) begin
            init_n = 1'b0;
            #1;
            check_all_zero("rst_mid");
            exp_addr_q.delete();
            exp_data_q.delete();
            repeat (2) begin
               @(posedge clk); #1;
               check("rst_hold_we", 32'(mem_we), 32'd0);
            end
            init_n = 1'b1;
            repeat (4) begin
               @(posedge clk); #1;
               check("post_rst_we",   32'(mem_we), 32'd0);
               check("post_rst_done", 32'(done),   32'd0);
            end
            return;
         end
         start = poke && (cyc == 10 || cyc == 40);
         if (start) begin
            seed = 6'h15; prel = 8'd12; tap_sel = 3'd5;
         end
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
      end
      check("done_latency", 32'(cyc), 32'd65);
      check("busy_off",     32'(busy), 32'd0);
      check("sb_drain",     32'(exp_addr_q.size()), 32'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      string msg;
      init_n = 1'b0; start = 1'b0; prel = 8'd0; tap_sel = 3'd0; seed = 6'd0;
      for (int i = 0; i < 64; i++) plain[i] = 8'($urandom);
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      init_n = 1'b1;
      @(posedge clk); #1;
      check_all_zero("idle");

      // Scenario 1: fixed preamble bytes with taps 6'h21 and seed 1.
      run_job(8'd7, 3'd0, 6'h01, 1'b0, 0);
      check("s1_b64", 32'(enc_mem[64]), 32'h5E);
      check("s1_b65", 32'(enc_mem[65]), 32'h5C);
      check("s1_b66", 32'(enc_mem[66]), 32'h58);
      for (int i = 64; i <= 70; i++) check("s1_top2", 32'(enc_mem[i][7:6]), 32'h1);
      check("s1_cfgerr", 32'(cfg_err), 32'd0);

      // Scenario 2: round trip of a text message.
      msg = "Mr_Watson_come_here";
      for (int i = 0; i < 64; i++) plain[i] = (i < msg.len()) ? msg[i] : 8'h5F;
      run_job(8'd9, 3'd3, 6'h2A, 1'b0, 0);
      for (int i = 0; i < 9; i++)
         check("s2_pre", 32'(enc_mem[64 + i] ^ {2'b00, stream[i]}), 32'h5F);
      for (int i = 0; i < 55; i++)
         check("s2_text", 32'(enc_mem[73 + i] ^ {2'b00, stream[9 + i]}), 32'(plain[i]));

      // Scenario 3: zero seed, bad tap index, short preamble are corrected.
      run_job(8'd3, 3'd7, 6'h00, 1'b0, 0);
      check("s3_cfgerr", 32'(cfg_err), 32'd1);
      check("s3_b64",    32'(enc_mem[64]), 32'h5E);

      // Scenario 4: start pulses during a run are ignored.
      for (int i = 0; i < 64; i++) plain[i] = 8'($urandom);
      run_job(8'd11, 3'd2, 6'h17, 1'b1, 0);
      check("s4_cfgerr", 32'(cfg_err), 32'd0);

      // Scenario 5: reset mid-run, then a clean run.
      run_job(8'd10, 3'd4, 6'h3B, 1'b0, 30);
      run_job(8'd7, 3'd5, 6'h05, 1'b0, 0);

      // Scenario 6: restart from FIN with new config, including a long prel.
      check("s6_done_before", 32'(done), 32'd1);
      run_job(8'd15, 3'd1, 6'h22, 1'b0, 0);
      run_job(8'd200, 3'd4, 6'h3F, 1'b0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
